// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller producing RAM addresses, accept strobes, level and flags.
// Build option FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int AF_THRESH = (1 << ADDR_SIZE) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 wr,
  input  logic                 rd,
  output logic [ADDR_SIZE-1:0] addr_w,
  output logic [ADDR_SIZE-1:0] addr_r,
  output logic                 we_enable,
  output logic                 rd_enable,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   level
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef logic [ADDR_SIZE:0] cnt_t;

  localparam cnt_t DEPTH_L = cnt_t'(DEPTH);
  localparam cnt_t AF_L    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_L    = cnt_t'(AE_THRESH);
  localparam cnt_t ONE_L   = cnt_t'(1);

  cnt_t ptr_w_q, ptr_w_d;
  cnt_t ptr_r_q, ptr_r_d;
  cnt_t level_q, level_d;

  // Handshake: wr/rd are requests that may be held at will; we_enable/rd_enable are the
  // accept strobes, and a transfer happens on each rising edge where its strobe is high.
  always_comb begin
    full         = (level_q == DEPTH_L);
    empty        = (level_q == '0);
    almost_full  = (level_q >= AF_L);
    almost_empty = (level_q <= AE_L);
    we_enable    = wr & ~full & ~clr;
    rd_enable    = rd & ~empty & ~clr;
  end

  always_comb begin
    ptr_w_d = ptr_w_q;
    ptr_r_d = ptr_r_q;
    level_d = level_q;
    if (clr) begin
      ptr_w_d = '0;
      ptr_r_d = '0;
      level_d = '0;
    end else begin
      if (we_enable) ptr_w_d = ptr_w_q + ONE_L;
      if (rd_enable) ptr_r_d = ptr_r_q + ONE_L;
      // A simultaneous accepted read and write leaves the occupancy unchanged.
      case ({we_enable, rd_enable})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_w_q <= '0;
      ptr_r_q <= '0;
      level_q <= '0;
    end else begin
      ptr_w_q <= ptr_w_d;
      ptr_r_q <= ptr_r_d;
      level_q <= level_d;
    end
  end

  assign addr_w = ptr_w_q[ADDR_SIZE-1:0];
  assign addr_r = ptr_r_q[ADDR_SIZE-1:0];
  assign level  = level_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset_n; a flush deliberately leaves the error history intact.
  always_comb begin
    overflow_d  = overflow_q | (wr & full & ~clr);
    underflow_d = underflow_q | (rd & empty & ~clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl (ADDR_SIZE=3): directed corner cases plus random traffic,
// checked per cycle against a queue-based occupancy model through an expected queue.
module tb_sync_fifo_ctrl;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int W     = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr, wr, rd;
  logic [AW-1:0] addr_w, addr_r;
  logic          we_enable, rd_enable, full, empty, almost_full, almost_empty;
  logic [AW:0]   level;
  logic          overflow, underflow;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  // reference model: FIFO contents as a queue of sequence numbers
  int q[$];
  int wcnt, rcnt, seq;
  bit ovf_m, udf_m;

  sync_fifo_ctrl #(.ADDR_SIZE(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr), .rd(rd),
    .addr_w(addr_w), .addr_r(addr_r), .we_enable(we_enable), .rd_enable(rd_enable),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

`ifndef FIFO_CTRL_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // clock / timeout
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // expected outputs for the current cycle, from the model state before the coming edge
  function automatic logic [W-1:0] model_expect(input bit w, input bit r, input bit c);
    int  lvl;
    bit  f, e, we_m, rd_m;
    lvl  = q.size();
    f    = (lvl == DEPTH);
    e    = (lvl == 0);
    we_m = w && !f && !c;
    rd_m = r && !e && !c;
    return {we_m, rd_m, 3'(wcnt % DEPTH), 3'(rcnt % DEPTH), f, e,
            (lvl >= AF), (lvl <= AE), 4'(lvl), ovf_m, udf_m};
  endfunction

  function automatic void model_step(input bit w, input bit r, input bit c);
    int  lvl;
    bit  f, e;
    lvl = q.size();
    f   = (lvl == DEPTH);
    e   = (lvl == 0);
    if (c) begin
      q.delete();
      wcnt = 0;
      rcnt = 0;
    end else begin
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      if (w && f) ovf_m = 1'b1;
      if (r && e) udf_m = 1'b1;
`endif
      if (r && !e) begin
        void'(q.pop_front());
        rcnt = (rcnt + 1) % (2 * DEPTH);
      end
      if (w && !f) begin
        q.push_back(seq++);
        wcnt = (wcnt + 1) % (2 * DEPTH);
      end
    end
  endfunction

  // driver tasks
  task automatic cycle(input bit w, input bit r, input bit c, input string tag);
    @(posedge clk);
    #1;
    wr  = w;
    rd  = r;
    clr = c;
    exp_q.push_back(model_expect(w, r, c));
    tag_q.push_back(tag);
    model_step(w, r, c);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    q.delete();
    wcnt = 0; rcnt = 0; ovf_m = 1'b0; udf_m = 1'b0;
    exp_q.push_back(model_expect(1'b0, 1'b0, 1'b0));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_q.push_back(model_expect(1'b0, 1'b0, 1'b0));
    tag_q.push_back(tag);
    reset_n = 1'b1;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] act, exp_v;
    string        tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act   = {we_enable, rd_enable, addr_w, addr_r, full, empty,
                 almost_full, almost_empty, level, overflow, underflow};
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s cycle %0d: actual=%h required=%h (we,rd,aw,ar,full,empty,af,ae,level,ovf,udf)",
                      tag, cyc, act, exp_v);
      end
    end
  end

  // stimulus
  initial begin
    reset_n = 1'b0;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    wcnt = 0; rcnt = 0; seq = 0; ovf_m = 1'b0; udf_m = 1'b0;

    do_reset("reset_state");

    for (int i = 0; i < 8; i++) cycle(1, 0, 0, "fill_8");
    cycle(1, 0, 0, "write_when_full");
    cycle(0, 0, 0, "hold_full");

    while (q.size() > 0) cycle(0, 1, 0, "drain");
    cycle(0, 1, 0, "read_when_empty");
    cycle(1, 1, 0, "rdwr_at_empty");
    cycle(0, 0, 0, "after_rdwr_empty");

    while (q.size() < 4) cycle(1, 0, 0, "to_level_4");
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, "rdwr_steady_4");

    while (q.size() < DEPTH) cycle(1, 0, 0, "to_full");
    cycle(1, 1, 0, "rdwr_at_full");
    cycle(0, 0, 0, "after_rdwr_full");

    while (q.size() > 5) cycle(0, 1, 0, "to_level_5");
    cycle(1, 0, 1, "clr_with_wr");
    cycle(0, 0, 0, "after_clr");

    for (int i = 0; i < 5; i++) cycle(1, (i % 2) == 1, 0, "burst_before_reset");
    do_reset("reset_mid_burst");
    cycle(0, 0, 0, "after_reset");

    for (int i = 0; i < 500; i++) begin
      int wp;
      wp = (i < 250) ? 70 : 35;
      if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
      else cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp + 10),
                 $urandom_range(0, 31) == 0, "random");
    end

    cycle(0, 0, 0, "idle_end");
    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL scoreboard_drain: actual %0d pending entries, required 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
